// File: rtl/staticio_tx_sched.sv
// rtl/staticio_tx_sched.sv - round-robin byte scheduler feeding the shared staticio UART transmitter
// Sources are NUM_REQ external requesters plus one internal heartbeat slot at index NUM_REQ.

module staticio_tx_sched #(
  parameter int         NUM_REQ    = 3,
  parameter int         HB_PERIOD  = 19_000_000,
  parameter logic [7:0] HB_BYTE    = 8'hF1,
  parameter int         GAP_CYCLES = 0,
  parameter int         START_TMO  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 hb_en,
  output logic                 uart_tdata,
  output logic [15:0]          uart_data,
  input  logic                 uart_txint,
  input  logic                 uart_tsre,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 tx_err,
  output logic                 hb_drop
);

  localparam int            N1       = NUM_REQ + 1;
  localparam int            HW       = $clog2(HB_PERIOD);
  localparam int            CW       = 16;
  localparam logic [HW-1:0] HB_LAST  = HW'(HB_PERIOD - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(START_TMO - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [2:0]    HB_ID    = 3'(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_ST, S_WAIT_DN, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    rr_q, rr_d, grant_q, grant_d;
  logic [15:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hb_cnt_q, hb_cnt_d;
  logic          hb_pend_q, hb_pend_d;
  logic          tx_err_q, tx_err_d;
  logic          hb_drop_q, hb_drop_d;

  logic [7:0]    src;
  logic [3:0]    idx;
  logic [2:0]    sel_idx;
  logic          sel_found;
  logic [7:0]    sel_byte;
  logic          hb_tick, hb_consume;

  assign src = 8'({hb_pend_q, req_valid});

  // First active source at or after the rotation pointer, wrapping over NUM_REQ+1 slots.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int i = 0; i < N1; i++) begin
      idx = {1'b0, rr_q} + 4'(i);
      if (idx >= 4'(N1)) idx = idx - 4'(N1);
      if (!sel_found && src[idx[2:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[2:0];
      end
    end
  end

  always_comb begin
    sel_byte = HB_BYTE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == 3'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    tx_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          data_d  = {7'b0, 1'b1, sel_byte};
          rr_d    = (sel_idx == HB_ID) ? 3'd0 : sel_idx + 3'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_ST;
      end
      S_WAIT_ST: begin
        if (uart_txint) begin
          state_d = S_WAIT_DN;
        end else if (cnt_q == TMO_LAST) begin
          tx_err_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DN: begin
        if (uart_tsre) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A tick landing on a pending heartbeat is only a drop when that heartbeat is not going out this cycle.
  assign hb_tick    = hb_en && (hb_cnt_q == HB_LAST);
  assign hb_consume = (state_q == S_IDLE && sel_found && sel_idx == HB_ID) ||
                      (state_q == S_LOAD && grant_q == HB_ID);

  always_comb begin
    hb_cnt_d  = hb_cnt_q;
    hb_pend_d = hb_pend_q;
    hb_drop_d = 1'b0;
    if (!hb_en) begin
      hb_cnt_d  = '0;
      hb_pend_d = 1'b0;
    end else if (hb_tick) begin
      hb_cnt_d  = '0;
      hb_pend_d = 1'b1;
      hb_drop_d = hb_pend_q && !hb_consume;
    end else begin
      hb_cnt_d = hb_cnt_q + HW'(1);
      if (state_q == S_LOAD && grant_q == HB_ID) hb_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      hb_cnt_q  <= '0;
      hb_pend_q <= 1'b0;
      tx_err_q  <= 1'b0;
      hb_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      hb_cnt_q  <= hb_cnt_d;
      hb_pend_q <= hb_pend_d;
      tx_err_q  <= tx_err_d;
      hb_drop_q <= hb_drop_d;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == S_LOAD) && (grant_q == 3'(i)) && req_valid[i];
    end
  end

  assign uart_tdata = (state_q == S_LOAD);
  assign uart_data  = data_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign tx_err     = tx_err_q;
  assign hb_drop    = hb_drop_q;

endmodule

// File: tb/tb_staticio_tx_sched.sv
// tb/tb_staticio_tx_sched.sv - directed self-checking bench for staticio_tx_sched
// A small UART responder answers each strobe with txint and a programmable frame length.

module tb_staticio_tx_sched;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        hb_en;
  logic        uart_tdata;
  logic [15:0] uart_data;
  logic        uart_txint;
  logic        uart_tsre;
  logic        busy;
  logic [2:0]  grant_id;
  logic        tx_err;
  logic        hb_drop;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_strobe = 0, n_txerr = 0, n_hbdrop = 0, t_hbdrop = 0, t_tsre = 0;
  int frame_len = 10;
  bit no_txint = 0;
  int t_prev, t_rel, c0, base;

  staticio_tx_sched #(
    .NUM_REQ(3), .HB_PERIOD(100), .HB_BYTE(8'hF1), .GAP_CYCLES(4), .START_TMO(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .hb_en(hb_en), .uart_tdata(uart_tdata), .uart_data(uart_data),
    .uart_txint(uart_txint), .uart_tsre(uart_tsre), .busy(busy), .grant_id(grant_id),
    .tx_err(tx_err), .hb_drop(hb_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tdata(input int limit, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (uart_tdata !== 1'b1 && n < limit);
    check(tag, {31'b0, uart_tdata}, 32'd1);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < limit);
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  // UART responder: txint one cycle after the strobe, shifter busy for frame_len cycles.
  initial begin
    uart_txint = 1'b0;
    uart_tsre  = 1'b1;
    forever begin
      @(negedge clk);
      if (uart_tdata === 1'b1 && !no_txint) begin
        uart_tsre = 1'b0;
        @(negedge clk); uart_txint = 1'b1;
        @(negedge clk); uart_txint = 1'b0;
        for (int i = 0; i < frame_len; i++) begin
          @(negedge clk);
          if (!reset_n) break;
        end
        uart_tsre = 1'b1;
        t_tsre = cyc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (uart_tdata === 1'b1) n_strobe++;
      if (tx_err === 1'b1) n_txerr++;
      if (hb_drop === 1'b1) begin n_hbdrop++; t_hbdrop = cyc; end
    end
  end

  initial begin
    logic [15:0] exp_w [4];
    logic [2:0]  exp_g [4];
    logic [2:0]  exp_r [4];
    exp_w = '{16'h0111, 16'h0122, 16'h0133, 16'h0111};
    exp_g = '{3'd0, 3'd1, 3'd2, 3'd0};
    exp_r = '{3'b001, 3'b010, 3'b100, 3'b001};

    reset_n = 1'b0; req_valid = '0; req_data = '0; hb_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_data", {16'b0, uart_data}, 0);
    check("rst_tdata", {31'b0, uart_tdata}, 0);
    check("rst_ready", {29'b0, req_ready}, 0);
    check("rst_grant", {29'b0, grant_id}, 0);
    check("rst_txerr", {31'b0, tx_err}, 0);
    check("rst_hbdrop", {31'b0, hb_drop}, 0);

    // single requester, held so a second frame follows the first
    reset_n = 1'b1;
    req_data = {8'h33, 8'h5A, 8'h11};
    req_valid = 3'b010;
    t_rel = cyc;
    wait_tdata(20, "t1_strobe");
    check("t1_latency", cyc - t_rel, 1);
    check("t1_word", {16'b0, uart_data}, 32'h015A);
    check("t1_ready", {29'b0, req_ready}, 3'b010);
    check("t1_grant", {29'b0, grant_id}, 1);
    check("t1_busy", {31'b0, busy}, 1);
    t_prev = cyc;
    @(negedge clk);
    check("t1_tdata_pulse", {31'b0, uart_tdata}, 0);
    check("t1_ready_pulse", {29'b0, req_ready}, 0);
    check("t1_data_held", {16'b0, uart_data}, 32'h015A);
    wait_tdata(60, "t1_strobe2");
    check("t1_frame_spacing", cyc - t_prev, 18);
    check("t1_gap_spacing", cyc - t_tsre, 6);
    req_valid = '0;
    wait_idle(40, "t1_idle");

    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk); reset_n = 1'b1;

    // round robin over all three requesters, then one re-request
    base = n_strobe;
    req_data = {8'h33, 8'h22, 8'h11};
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_tdata(60, "t2_strobe");
      check("t2_word", {16'b0, uart_data}, {16'b0, exp_w[k]});
      check("t2_grant", {29'b0, grant_id}, {29'b0, exp_g[k]});
      check("t2_ready", {29'b0, req_ready}, {29'b0, exp_r[k]});
      if (k > 0) check("t2_gap_spacing", cyc - t_tsre, 6);
      req_valid = req_valid & ~req_ready;
      if (k == 2) req_valid[0] = 1'b1;
    end
    wait_idle(40, "t2_idle");
    repeat (30) @(negedge clk);
    check("t2_strobe_count", n_strobe - base, 4);

    // start timeout: no txint ever comes back
    no_txint = 1'b1;
    req_valid = 3'b100;
    wait_tdata(20, "t4_strobe");
    check("t4_word", {16'b0, uart_data}, 32'h0133);
    t_prev = cyc;
    req_valid = '0;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (tx_err !== 1'b1 && n < 40);
    end
    check("t4_txerr", {31'b0, tx_err}, 1);
    check("t4_txerr_latency", cyc - t_prev, 17);
    check("t4_idle", {31'b0, busy}, 0);
    @(negedge clk);
    check("t4_txerr_pulse", {31'b0, tx_err}, 0);
    no_txint = 1'b0;

    // asynchronous reset while the frame is shifting out
    frame_len = 200;
    req_valid = 3'b110;
    wait_tdata(20, "t5_strobe");
    check("t5_grant_pre", {29'b0, grant_id}, 1);
    repeat (5) @(negedge clk);
    check("t5_busy_pre", {31'b0, busy}, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_busy", {31'b0, busy}, 0);
    check("t5_async_data", {16'b0, uart_data}, 0);
    check("t5_async_ready", {29'b0, req_ready}, 0);
    @(negedge clk);
    frame_len = 10;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    t_rel = cyc;
    wait_tdata(20, "t5_strobe_post");
    check("t5_latency", cyc - t_rel, 1);
    check("t5_grant_post", {29'b0, grant_id}, 1);
    check("t5_word_post", {16'b0, uart_data}, 32'h0122);
    req_valid = '0;
    wait_idle(40, "t5_idle");

    // heartbeat every 100 cycles, then a long frame that makes a tick overlap a pending beat
    @(negedge clk);
    hb_en = 1'b1;
    c0 = cyc;
    base = n_strobe;
    wait_tdata(150, "t3_hb1");
    check("t3_hb1_time", cyc - c0, 101);
    check("t3_hb1_word", {16'b0, uart_data}, 32'h01F1);
    check("t3_hb1_grant", {29'b0, grant_id}, 3);
    check("t3_hb1_ready", {29'b0, req_ready}, 0);
    wait_tdata(150, "t3_hb2");
    check("t3_hb2_time", cyc - c0, 201);
    frame_len = 250;
    wait_tdata(300, "t3_hb3");
    check("t3_hb3_time", cyc - c0, 459);
    check("t3_hb3_gap", cyc - t_tsre, 6);
    check("t3_hb3_word", {16'b0, uart_data}, 32'h01F1);
    hb_en = 1'b0;
    frame_len = 10;
    wait_idle(60, "t3_idle");
    repeat (150) @(negedge clk);
    check("t3_strobe_count", n_strobe - base, 3);
    check("t3_drop_count", n_hbdrop, 1);
    check("t3_drop_time", t_hbdrop - c0, 400);
    check("txerr_total", n_txerr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
